// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clock period meter.
// Holds the measurement FSM encoding and the default counter width.
package clk_meas_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic {
        ARM  = 1'b0,
        MEAS = 1'b1
    } meas_state_t;

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchronizer for an asynchronous waveform plus a delay flop for edge detection.
// rise pulses for one clk_in cycle, two edges after sig_in is first sampled high.
module sync_rise_det (
    input  logic clk_in,
    input  logic rst,
    input  logic sig_in,
    output logic s2,
    output logic rise
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    // Delayed copy of s2; named _dly to keep _d free for next-state values.
    logic s2_dly_q, s2_dly_d;

    always_comb begin
        s1_d     = sig_in;
        s2_d     = s1_q;
        s2_dly_d = s2_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s2_dly_q <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s2_dly_q <= s2_dly_d;
        end
    end

    assign s2   = s2_q;
    assign rise = s2_q & ~s2_dly_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a divided clock in clk_in cycles, rise to rise.
// Result registers two edges after the synchronized rise; a held result is overwritten (overrun) if not accepted.
module clock_period_meter
    import clk_meas_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             meas_ready,
    input  logic             clr_status,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             overrun,
    output logic             timeout,
    output logic             armed
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic s2, rise;

    meas_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic             new_res;

    sync_rise_det u_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .sig_in (sig_in),
        .s2     (s2),
        .rise   (rise)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = valid_q;
        overrun_d = overrun_q & ~clr_status;
        timeout_d = timeout_q & ~clr_status;
        new_res   = 1'b0;

        case (state_q)
            ARM: begin
                if (rise) begin
                    state_d = MEAS;
                    cnt_d   = CNT_ONE;
                    hcnt_d  = CNT_ONE;
                end
            end
            MEAS: begin
                if (rise) begin
                    new_res  = 1'b1;
                    period_d = cnt_q;
                    high_d   = hcnt_q;
                    cnt_d    = CNT_ONE;
                    hcnt_d   = CNT_ONE;
                end else if (cnt_q == CNT_MAX) begin
                    // Saturated without a rise: give up and re-arm rather than wrap.
                    state_d   = ARM;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    hcnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (s2) begin
                        hcnt_d = hcnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ARM;
            end
        endcase

        // A fresh result beats a same-cycle acceptance; only an unaccepted one counts as overrun.
        if (new_res) begin
            valid_d = 1'b1;
            if (valid_q && !meas_ready) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && meas_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= ARM;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign period_cnt = period_q;
    assign high_cnt   = high_q;
    assign meas_valid = valid_q;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;
    assign armed      = (state_q == ARM);

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed and randomized bench for clock_period_meter (CNT_W=8) against a timestamp-based reference model.
module tb_clock_period_meter;

    localparam int W    = 8;
    localparam int MAXC = (1 << W) - 1;
    localparam int LVN  = 1024;

    logic         clk_in = 1'b0;
    logic         rst = 1'b1;
    logic         sig_in = 1'b0;
    logic         meas_ready = 1'b0;
    logic         clr_status = 1'b0;
    logic [W-1:0] period_cnt, high_cnt;
    logic         meas_valid, overrun, timeout, armed;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: level seen by the meter lags sig_in by the synchronizer depth.
    bit d1, d2, d3;
    bit lv [LVN];
    int edge_n = 0;
    int last_rise = 0;
    bit m_armed = 1'b1;
    int m_p = 0, m_h = 0;
    bit m_valid = 1'b0, m_ovr = 1'b0, m_to = 1'b0;
    bit m_res = 1'b0;

    bit fix_on = 1'b0;
    int fix_p = 0, fix_h = 0;
    bit ovr_watch = 1'b0;
    int res_cnt = 0;
    bit saw_valid = 1'b0;

    clock_period_meter #(.CNT_W(W)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .sig_in     (sig_in),
        .meas_ready (meas_ready),
        .clr_status (clr_status),
        .period_cnt (period_cnt),
        .high_cnt   (high_cnt),
        .meas_valid (meas_valid),
        .overrun    (overrun),
        .timeout    (timeout),
        .armed      (armed)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit set_ovr, set_to;
        int p, h;
        m_res   = 1'b0;
        set_ovr = 1'b0;
        set_to  = 1'b0;
        p = 0;
        h = 0;
        if (rst) begin
            d1 = 0; d2 = 0; d3 = 0;
            m_armed = 1'b1;
            m_p = 0; m_h = 0;
            m_valid = 1'b0; m_ovr = 1'b0; m_to = 1'b0;
        end else begin
            lv[edge_n % LVN] = d2;
            if (d2 && !d3) begin
                if (m_armed) begin
                    m_armed   = 1'b0;
                    last_rise = edge_n;
                end else begin
                    p = edge_n - last_rise;
                    for (int i = last_rise; i < edge_n; i++) h += int'(lv[i % LVN]);
                    last_rise = edge_n;
                    m_res     = 1'b1;
                end
            end else if (!m_armed && (edge_n - last_rise) == MAXC) begin
                set_to  = 1'b1;
                m_armed = 1'b1;
            end
            if (m_res) begin
                if (m_valid && !meas_ready) set_ovr = 1'b1;
                m_valid = 1'b1;
                m_p = p;
                m_h = h;
            end else if (m_valid && meas_ready) begin
                m_valid = 1'b0;
            end
            m_ovr = (m_ovr && !clr_status) || set_ovr;
            m_to  = (m_to && !clr_status) || set_to;
            d3 = d2; d2 = d1; d1 = sig_in;
        end
        edge_n++;
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #2;
        chk("period_cnt", 32'(period_cnt), 32'(m_p));
        chk("high_cnt", 32'(high_cnt), 32'(m_h));
        chk("meas_valid", 32'(meas_valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("armed", 32'(armed), 32'(m_armed));
        if (m_res) res_cnt++;
        if (fix_on && m_res) begin
            chk("fixed_period", 32'(period_cnt), 32'(fix_p));
            chk("fixed_high", 32'(high_cnt), 32'(fix_h));
        end
        if (ovr_watch && m_res) chk("overrun_vs_result_no", 32'(overrun), 32'(res_cnt >= 2));
        if (meas_valid === 1'b1) saw_valid = 1'b1;
    endtask

    task automatic drive(input bit v, input int n, input bit rnd);
        sig_in = v;
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                meas_ready = ($urandom_range(0, 3) != 0);
                clr_status = ($urandom_range(0, 15) == 0);
            end
            tick();
        end
        if (rnd) clr_status = 1'b0;
    endtask

    task automatic wave(input int hi, input int lo, input int nper);
        for (int i = 0; i < nper; i++) begin
            drive(1'b1, hi, 1'b0);
            drive(1'b0, lo, 1'b0);
        end
    endtask

    task automatic do_reset();
        sig_in = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        res_cnt = 0;
        saw_valid = 1'b0;
    endtask

    initial begin
        int k;

        // Reset state
        do_reset();
        chk("rst_armed", 32'(armed), 32'd1);
        chk("rst_valid", 32'(meas_valid), 32'd0);
        chk("rst_period", 32'(period_cnt), 32'd0);

        // /4 with ready held high
        meas_ready = 1'b1;
        drive(1'b0, 4, 1'b0);
        fix_on = 1'b1; fix_p = 4; fix_h = 2;
        wave(2, 2, 6);
        fix_on = 1'b0;
        chk("div4_overrun", 32'(overrun), 32'd0);
        chk("div4_results", 32'(res_cnt >= 4), 32'd1);

        // /26 and /32
        do_reset();
        drive(1'b0, 3, 1'b0);
        fix_on = 1'b1; fix_p = 26; fix_h = 13;
        wave(13, 13, 3);
        do_reset();
        drive(1'b0, 3, 1'b0);
        fix_p = 32; fix_h = 16;
        wave(16, 16, 3);
        // E0 samples sig_in high; the result registers on E2, the third edge counting E0.
        sig_in = 1'b1;
        tick(); chk("latency_e0", 32'(meas_valid), 32'd0);
        tick(); chk("latency_e1", 32'(meas_valid), 32'd0);
        tick(); chk("latency_e2", 32'(meas_valid), 32'd1);
        drive(1'b1, 13, 1'b0);
        drive(1'b0, 16, 1'b0);
        fix_on = 1'b0;

        // Consumer stalls: overrun on the second unaccepted result
        do_reset();
        meas_ready = 1'b0;
        drive(1'b0, 4, 1'b0);
        ovr_watch = 1'b1;
        wave(2, 2, 3);
        drive(1'b0, 3, 1'b0);
        ovr_watch = 1'b0;
        chk("stall_overrun", 32'(overrun), 32'd1);
        chk("stall_valid", 32'(meas_valid), 32'd1);
        chk("stall_period", 32'(period_cnt), 32'd4);
        meas_ready = 1'b1;
        tick();
        chk("accept_clears", 32'(meas_valid), 32'd0);

        // clr_status racing an overrun event, then a solo clear
        do_reset();
        meas_ready = 1'b0;
        drive(1'b0, 4, 1'b0);
        wave(2, 2, 2);
        chk("race_pre_valid", 32'(meas_valid), 32'd1);
        sig_in = 1'b1;
        tick();
        tick();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("race_set_wins", 32'(overrun), 32'd1);
        drive(1'b0, 2, 1'b0);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("solo_clear", 32'(overrun), 32'd0);

        // Timeout after a single rise
        do_reset();
        meas_ready = 1'b1;
        drive(1'b0, 3, 1'b0);
        drive(1'b1, 2, 1'b0);
        sig_in = 1'b0;
        k = 0;
        while (armed !== 1'b0 && k < 10) begin tick(); k++; end
        chk("to_armed_drop", 32'(armed), 32'd0);
        k = 0;
        while (timeout !== 1'b1 && k < 300) begin tick(); k++; end
        chk("to_cycles", 32'(k), 32'(MAXC));
        chk("to_flag", 32'(timeout), 32'd1);
        chk("to_rearmed", 32'(armed), 32'd1);
        saw_valid = 1'b0;
        fix_on = 1'b1; fix_p = 4; fix_h = 2;
        wave(2, 2, 3);
        fix_on = 1'b0;
        chk("to_then_result", 32'(saw_valid), 32'd1);

        // Reset mid-period of /16
        do_reset();
        meas_ready = 1'b1;
        drive(1'b0, 3, 1'b0);
        wave(8, 8, 2);
        drive(1'b1, 8, 1'b0);
        drive(1'b0, 3, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_period", 32'(period_cnt), 32'd0);
        chk("midrst_high", 32'(high_cnt), 32'd0);
        chk("midrst_valid", 32'(meas_valid), 32'd0);
        chk("midrst_flags", 32'({overrun, timeout}), 32'd0);
        chk("midrst_armed", 32'(armed), 32'd1);
        res_cnt = 0;
        drive(1'b0, 5, 1'b0);
        fix_on = 1'b1; fix_p = 16; fix_h = 8;
        wave(8, 8, 3);
        fix_on = 1'b0;
        chk("midrst_results", 32'(res_cnt >= 1), 32'd1);

        // Randomized waveforms, handshake and clears
        do_reset();
        for (int i = 0; i < 60; i++) begin
            drive(1'b1, int'($urandom_range(1, 20)), 1'b1);
            if ($urandom_range(0, 9) == 0)
                drive(1'b0, int'($urandom_range(250, 262)), 1'b1);
            else
                drive(1'b0, int'($urandom_range(1, 20)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
